// File: rtl/vga_pkg.sv
// Shared VGA/framebuffer constants, pixel type and CPU request payload.
package vga_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = 800;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = 525;

    localparam int unsigned FB_W     = 160;
    localparam int unsigned FB_H     = 120;
    localparam int unsigned SCALE_SH = 2;
    localparam int unsigned FB_DEPTH = FB_W * FB_H;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned PIX_W    = 10;

    typedef logic [DATA_W-1:0] rgb332_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        rgb332_t           wdata;
    } cpu_req_t;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_PEND  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Screen pixel (x,y) to linear framebuffer address; row*160 done as (r<<7)+(r<<5).
module fb_addr_gen
    import vga_pkg::*;
(
    input  logic [PIX_W-1:0]  pixel_x,
    input  logic [PIX_W-1:0]  pixel_y,
    output logic [ADDR_W-1:0] addr_c
);

    localparam int unsigned CRD_W = PIX_W - SCALE_SH;
    localparam int unsigned SUM_W = ADDR_W + 1;

    logic [CRD_W-1:0] row;
    logic [CRD_W-1:0] col;
    logic [SUM_W-1:0] sum;

    always_comb begin
        row    = pixel_y[PIX_W-1:SCALE_SH];
        col    = pixel_x[PIX_W-1:SCALE_SH];
        sum    = (SUM_W'(row) << 7) + (SUM_W'(row) << 5) + SUM_W'(col);
        addr_c = sum[ADDR_W-1:0];
    end

    // Sub-pixel bits and the carry only matter outside the visible area.
    logic unused_bits;
    assign unused_bits = ^{pixel_x[SCALE_SH-1:0], pixel_y[SCALE_SH-1:0], sum[SUM_W-1]};

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch owns the first clk of each pixel,
// CPU ops wait in a one-entry holding register and issue in any other cycle.
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [PIX_W-1:0]  pixel_x,
    input  logic [PIX_W-1:0]  pixel_y,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rgb,
    output logic              hsync,
    output logic              vsync
);

    localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_DEPTH);

    logic              disp_req_c;
    logic [ADDR_W-1:0] disp_addr_c;
    logic              issue_c;
    logic              in_range_c;
    logic              accept_c;

    hold_state_e state_q, state_d;
    cpu_req_t    hold_q, hold_d;
    logic        disp_q, disp_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_oor_q, rd_oor_d;
    logic        rvalid_q, rvalid_d;
    rgb332_t     rdata_q, rdata_d;
    rgb332_t     rgb_q, rgb_d;
    logic [1:0]  hs_q, hs_d;
    logic [1:0]  vs_q, vs_d;

    fb_addr_gen u_addr_gen (
        .pixel_x (pixel_x),
        .pixel_y (pixel_y),
        .addr_c  (disp_addr_c)
    );

    // Display slot: first clk of every active pixel period.
    assign disp_req_c = video_on & ~p_tick & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HOLD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD_EMPTY: if (accept_c) state_d = HOLD_PEND;
            HOLD_PEND:  if (issue_c && !accept_c) state_d = HOLD_EMPTY;
            default:    state_d = HOLD_EMPTY;
        endcase
    end

    // RAM port mux and CPU handshake; cpu_ready stays high in the issue cycle.
    always_comb begin
        issue_c    = 1'b0;
        in_range_c = 1'b0;
        cpu_ready  = 1'b0;
        accept_c   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = hold_q.addr;
        mem_wdata  = hold_q.wdata;
        addr_err   = 1'b0;

        issue_c    = (state_q == HOLD_PEND) && !disp_req_c;
        in_range_c = hold_q.addr < FB_LIMIT;
        cpu_ready  = !reset && ((state_q == HOLD_EMPTY) || issue_c);
        accept_c   = cpu_valid && cpu_ready;
        mem_en     = disp_req_c || (issue_c && in_range_c);
        mem_we     = issue_c && in_range_c && hold_q.we;
        addr_err   = issue_c && !in_range_c;
        if (disp_req_c) begin
            mem_addr = disp_addr_c;
        end
    end

    always_comb begin
        hold_d    = hold_q;
        disp_d    = disp_req_c;
        rd_pend_d = issue_c && !hold_q.we;
        rd_oor_d  = !in_range_c;
        rvalid_d  = rd_pend_q;
        rdata_d   = '0;
        rgb_d     = rgb_q;
        hs_d      = {hs_q[0], hsync_in};
        vs_d      = {vs_q[0], vsync_in};

        if (accept_c) begin
            hold_d.we    = cpu_we;
            hold_d.addr  = cpu_addr;
            hold_d.wdata = cpu_wdata;
        end
        // Out-of-range reads never touched the RAM, so return zero instead of stale data.
        if (rd_pend_q && !rd_oor_q) begin
            rdata_d = mem_rdata;
        end
        if (p_tick) begin
            rgb_d = disp_q ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            disp_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_oor_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rgb_q     <= '0;
            hs_q      <= '0;
            vs_q      <= '0;
        end else begin
            hold_q    <= hold_d;
            disp_q    <= disp_d;
            rd_pend_q <= rd_pend_d;
            rd_oor_q  <= rd_oor_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rdata_q;
    assign rgb        = rgb_q;
    assign hsync      = hs_q[1];
    assign vsync      = vs_q[1];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural single-port synchronous RAM.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              p_tick = 1'b0;
    logic              video_on = 1'b0;
    logic [9:0]        pixel_x = '0;
    logic [9:0]        pixel_y = '0;
    logic              hsync_in = 1'b0;
    logic              vsync_in = 1'b0;
    logic              cpu_valid = 1'b0;
    logic              cpu_we = 1'b0;
    logic [14:0]       cpu_addr = '0;
    logic [7:0]        cpu_wdata = '0;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [7:0]        cpu_rdata;
    logic              addr_err;
    logic              mem_en;
    logic              mem_we;
    logic [14:0]       mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = '0;
    logic [7:0]        rgb;
    logic              hsync;
    logic              vsync;

    logic              ld_en = 1'b0;
    logic [14:0]       ld_addr = '0;
    logic [7:0]        ld_data = '0;
    logic [7:0]        ram [0:32767] = '{default: 8'h00};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .cpu_valid  (cpu_valid),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .addr_err   (addr_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    // Read-before-write synchronous RAM with a bench-side preload port.
    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        vo;
        logic        tick;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        exp_en;
        logic [14:0] exp_addr;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 10'd0,   10'd0,   1'b1, 15'd0};
        vecs[1] = '{1'b1, 1'b0, 10'd3,   10'd4,   1'b1, 15'd160};
        vecs[2] = '{1'b1, 1'b0, 10'd639, 10'd479, 1'b1, 15'd19199};
        vecs[3] = '{1'b1, 1'b0, 10'd4,   10'd0,   1'b1, 15'd1};
        vecs[4] = '{1'b1, 1'b0, 10'd100, 10'd200, 1'b1, 15'd8025};
        vecs[5] = '{1'b0, 1'b0, 10'd700, 10'd100, 1'b0, 15'd0};
        vecs[6] = '{1'b1, 1'b1, 10'd8,   10'd8,   1'b0, 15'd0};
        vecs[7] = '{1'b1, 1'b0, 10'd7,   10'd3,   1'b1, 15'd1};
        vecs[8] = '{1'b1, 1'b0, 10'd320, 10'd240, 1'b1, 15'd9680};

        // Preload RAM while reset is held.
        @(negedge clk); ld_en = 1'b1; ld_addr = 15'd0;  ld_data = 8'hE0;
        @(negedge clk); ld_addr = 15'd42; ld_data = 8'h55;
        @(negedge clk); ld_en = 1'b0;
        #1;
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_hsync", hsync, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);

        @(negedge clk); reset = 1'b0;
        #1 chk("rel_cpu_ready", cpu_ready, 1);

        // Read of addr 5 captured, then stuck behind a display slot, then reset.
        @(negedge clk);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd5;
        video_on = 1'b1; p_tick = 1'b1;
        #1 chk("pend_accept_ready", cpu_ready, 1);
        @(negedge clk);
        cpu_valid = 1'b0; p_tick = 1'b0;
        #1;
        chk("pend_wait_ready", cpu_ready, 0);
        chk("pend_wait_addr", mem_addr, 0);
        chk("pend_wait_we", mem_we, 0);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_ready", cpu_ready, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            video_on = 1'b0; p_tick = ~p_tick;
            #1;
            chk("mid_rst_rvalid", cpu_rvalid, 0);
            chk("mid_rst_we", mem_we, 0);
        end
        @(negedge clk); reset = 1'b0;
        #1 chk("rel2_cpu_ready", cpu_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            p_tick = ~p_tick;
            #1;
            chk("post_rst_rvalid", cpu_rvalid, 0);
            chk("post_rst_mem_en", mem_en, 0);
            chk("post_rst_rgb", rgb, 0);
            chk("post_rst_hsync", hsync, 0);
            chk("post_rst_vsync", vsync, 0);
        end

        // Display address generation table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            video_on = vecs[i].vo; p_tick = vecs[i].tick;
            pixel_x = vecs[i].x;   pixel_y = vecs[i].y;
            #1;
            chk($sformatf("disp_en[%0d]", i), mem_en, vecs[i].exp_en);
            chk($sformatf("disp_we[%0d]", i), mem_we, 0);
            if (vecs[i].exp_en) chk($sformatf("disp_addr[%0d]", i), mem_addr, vecs[i].exp_addr);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            video_on = 1'b0; p_tick = (i % 2 == 0);
        end

        // Pixel (0,0) fetch, rgb two clks later held two clks, sync aligned.
        @(negedge clk);
        video_on = 1'b1; p_tick = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        #1;
        chk("px0_mem_en", mem_en, 1);
        chk("px0_mem_addr", mem_addr, 0);
        @(negedge clk);
        p_tick = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        #1;
        chk("px0_rgb_early", rgb, 0);
        chk("px0_hsync_early", hsync, 0);
        @(negedge clk);
        video_on = 1'b0; p_tick = 1'b0; pixel_x = 10'd700;
        #1;
        chk("px0_rgb", rgb, 8'hE0);
        chk("px0_hsync", hsync, 1);
        chk("px0_vsync", vsync, 1);
        chk("blank_mem_en", mem_en, 0);
        @(negedge clk);
        p_tick = 1'b1;
        #1;
        chk("px0_rgb_hold", rgb, 8'hE0);
        chk("px0_hsync_end", hsync, 0);
        @(negedge clk);
        p_tick = 1'b0;
        #1 chk("blank_rgb", rgb, 0);

        // CPU write of 42 during active video, then display fetch of 42.
        @(negedge clk);
        video_on = 1'b1; p_tick = 1'b0; pixel_x = 10'd168; pixel_y = 10'd0;
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd42; cpu_wdata = 8'h1C;
        #1;
        chk("wr_accept_ready", cpu_ready, 1);
        chk("wr_disp_addr", mem_addr, 42);
        chk("wr_disp_we", mem_we, 0);
        @(negedge clk);
        cpu_valid = 1'b0; p_tick = 1'b1;
        #1;
        chk("wr_issue_en", mem_en, 1);
        chk("wr_issue_we", mem_we, 1);
        chk("wr_issue_addr", mem_addr, 42);
        chk("wr_issue_wdata", mem_wdata, 8'h1C);
        chk("wr_issue_ready", cpu_ready, 1);
        @(negedge clk);
        p_tick = 1'b0;
        #1;
        chk("wr_old_rgb", rgb, 8'h55);
        chk("wr_fetch_we", mem_we, 0);
        @(negedge clk);
        p_tick = 1'b1;
        #1 chk("wr_idle_we", mem_we, 0);
        @(negedge clk);
        video_on = 1'b0; p_tick = 1'b0;
        #1 chk("wr_new_rgb", rgb, 8'h1C);

        // Blanking: back-to-back read 42, read 19300, write 19200.
        @(negedge clk);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd42;
        #1 chk("b2b_ready0", cpu_ready, 1);
        @(negedge clk);
        cpu_addr = 15'd19300;
        #1;
        chk("b2b_issue_en", mem_en, 1);
        chk("b2b_issue_addr", mem_addr, 42);
        chk("b2b_issue_we", mem_we, 0);
        chk("b2b_ready1", cpu_ready, 1);
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 15'd19200; cpu_wdata = 8'hAA;
        #1;
        chk("oor_rd_err", addr_err, 1);
        chk("oor_rd_en", mem_en, 0);
        chk("b2b_ready2", cpu_ready, 1);
        chk("rd_rvalid_early", cpu_rvalid, 0);
        @(negedge clk);
        cpu_valid = 1'b0;
        #1;
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", cpu_rdata, 8'h1C);
        chk("oor_wr_err", addr_err, 1);
        chk("oor_wr_en", mem_en, 0);
        chk("oor_wr_we", mem_we, 0);
        @(negedge clk);
        #1;
        chk("oor_rd_rvalid", cpu_rvalid, 1);
        chk("oor_rd_rdata", cpu_rdata, 0);
        chk("err_pulse_end", addr_err, 0);
        chk("idle_mem_en", mem_en, 0);
        @(negedge clk);
        #1;
        chk("rvalid_end", cpu_rvalid, 0);
        chk("err_idle", addr_err, 0);
        chk("oor_wr_dropped", ram[19200], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
